// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring, one quotient bit per cycle, 33-cycle latency.
// Result is held on the write-back port until granted; optional macro DIV_FAST_SPECIAL_EN short-cuts special operands.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  input  logic        kill,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wd,
  output logic        busy,
  output logic [4:0]  busy_rd
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic        op_rem_q;
  logic        sa_q, sb_q, bz_q;
  logic [31:0] dvd_q, dvs_q, rem_q;
  logic [4:0]  cnt_q;
  logic        in_ready_q, wb_valid_q, busy_q;
  logic [4:0]  wb_rd_q, busy_rd_q;
  logic [31:0] wd_q;

  logic        in_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh_d, diff_d;
  logic        ge_d;
  logic [31:0] rem_d, dvd_d;
  logic [31:0] quo_fix, rem_fix, wd_fix;

  always_comb begin
    in_signed = ~in_op[0];
    a_neg     = in_signed & in_a[31];
    b_neg     = in_signed & in_b[31];
    abs_a     = a_neg ? (32'd0 - in_a) : in_a;
    abs_b     = b_neg ? (32'd0 - in_b) : in_b;

    // The shifted partial remainder can reach 33 bits; a clear borrow bit means rem >= divisor.
    rem_sh_d  = {rem_q, dvd_q[31]};
    diff_d    = rem_sh_d - {1'b0, dvs_q};
    ge_d      = ~diff_d[32];
    rem_d     = ge_d ? diff_d[31:0] : rem_sh_d[31:0];
    dvd_d     = {dvd_q[30:0], ge_d};

    quo_fix   = ((sa_q ^ sb_q) & ~bz_q) ? (32'd0 - dvd_q) : dvd_q;
    rem_fix   = sa_q ? (32'd0 - rem_q) : rem_q;
    wd_fix    = op_rem_q ? rem_fix : quo_fix;
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic        fast_hit;
  logic [31:0] fast_wd;

  always_comb begin
    fast_hit = 1'b0;
    fast_wd  = 32'd0;
    if (in_b == 32'd0) begin
      fast_hit = 1'b1;
      fast_wd  = in_op[1] ? in_a : 32'hFFFF_FFFF;
    end else if (in_a == 32'd0) begin
      fast_hit = 1'b1;
      fast_wd  = 32'd0;
    end else if (in_signed && in_a == 32'h8000_0000 && in_b == 32'hFFFF_FFFF) begin
      fast_hit = 1'b1;
      fast_wd  = in_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`endif

  always_ff @(posedge clk) begin
    // Reset and flush share one path: everything back to an empty, ready unit.
    if (!rst_n || kill) begin
      state_q    <= IDLE;
      op_rem_q   <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      bz_q       <= 1'b0;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      cnt_q      <= 5'd0;
      in_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wb_rd_q    <= 5'd0;
      busy_rd_q  <= 5'd0;
      wd_q       <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_rem_q   <= in_op[1];
            sa_q       <= a_neg;
            sb_q       <= b_neg;
            bz_q       <= (in_b == 32'd0);
            dvd_q      <= abs_a;
            dvs_q      <= abs_b;
            rem_q      <= 32'd0;
            cnt_q      <= 5'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            busy_rd_q  <= in_rd;
            state_q    <= CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_hit) begin
              wd_q       <= fast_wd;
              wb_rd_q    <= in_rd;
              wb_valid_q <= 1'b1;
              state_q    <= DONE;
            end
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          wd_q       <= wd_fix;
          wb_rd_q    <= busy_rd_q;
          wb_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (wb_ready) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            wb_rd_q    <= 5'd0;
            busy_rd_q  <= 5'd0;
            wd_q       <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_wd    = wd_q;
  assign busy     = busy_q;
  assign busy_rd  = busy_rd_q;
  assign wb_we    = wb_valid_q & wb_ready & (wb_rd_q != 5'd0);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, backpressure, kill and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_rd;
  logic        kill;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        busy;
  logic [4:0]  busy_rd;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int SLOW_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 0;
`else
  localparam int SPEC_LAT = 33;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .kill(kill),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_wd(wb_wd), .busy(busy), .busy_rd(busy_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_wb_we"},    {31'd0, wb_we},    32'd0);
    check({tag, "_wb_rd"},    {27'd0, wb_rd},    32'd0);
    check({tag, "_wb_wd"},    wb_wd,             32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_busy_rd"},  {27'd0, busy_rd},  32'd0);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    start(op, a, b, rd);
    lat = 0;
    while (!wb_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_wd"}, wb_wd, exp);
    check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_busy_rd"}, {27'd0, busy_rd}, {27'd0, rd});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, {31'd0, wb_valid}, 32'd1);
      check({tag, "_hold_wd"}, wb_wd, exp);
      check({tag, "_hold_rd"}, {27'd0, wb_rd}, {27'd0, rd});
      check({tag, "_hold_we"}, {31'd0, wb_we}, 32'd0);
      check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    #1;
    check({tag, "_we"}, {31'd0, wb_we}, {31'd0, (rd != 5'd0)});
    @(negedge clk);
    wb_ready = 1'b0;
    check({tag, "_post_rdy"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_post_vld"}, {31'd0, wb_valid}, 32'd0);
    check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_post_we"}, {31'd0, wb_we}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_rd = '0;
    kill = 1'b0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_neg",  OP_DIV,  32'hFFFF_FF9C, 32'd7, 5'd1, 32'hFFFF_FFF2, SLOW_LAT, 0);
    run_op("rem_neg",  OP_REM,  32'hFFFF_FF9C, 32'd7, 5'd2, 32'hFFFF_FFFE, SLOW_LAT, 0);
    run_op("divu",     OP_DIVU, 32'd100,       32'd7, 5'd3, 32'h0000_000E, SLOW_LAT, 0);
    run_op("remu",     OP_REMU, 32'd100,       32'd7, 5'd4, 32'h0000_0002, SLOW_LAT, 0);
    run_op("div_nn",   OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd9, 32'd3, SLOW_LAT, 0);
    run_op("rem_nn",   OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFF, SLOW_LAT, 0);
    run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, SLOW_LAT, 0);
    run_op("remu_hex", OP_REMU, 32'h1234_5678, 32'h100, 5'd12, 32'h0000_0078, SLOW_LAT, 0);
    run_op("divu_z",   OP_DIVU, 32'd5,         32'd0, 5'd5, 32'hFFFF_FFFF, SPEC_LAT, 0);
    run_op("div_z",    OP_DIV,  32'd7,         32'd0, 5'd13, 32'hFFFF_FFFF, SPEC_LAT, 0);
    run_op("rem_z",    OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFB, SPEC_LAT, 0);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, SPEC_LAT, 0);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, SPEC_LAT, 0);
    run_op("bp",       OP_DIVU, 32'd100,       32'd7, 5'd14, 32'h0000_000E, SLOW_LAT, 5);
    run_op("rd0",      OP_DIVU, 32'd20,        32'd6, 5'd0, 32'd3, SLOW_LAT, 2);

    // Kill in the middle of the iterations.
    start(OP_DIVU, 32'd1000, 32'd3, 5'd15);
    check("kill_busy_pre", {31'd0, busy}, 32'd1);
    check("kill_busy_rd_pre", {27'd0, busy_rd}, 32'd15);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("kill_no_wb", {31'd0, seen}, 32'd0);
    run_op("after_kill", OP_DIVU, 32'd9, 32'd3, 5'd16, 32'd3, SLOW_LAT, 0);

    // Kill beats a simultaneous request.
    in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd3; in_rd = 5'd17;
    in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("kill_vs_req_busy", {31'd0, busy}, 32'd0);
    check("kill_vs_req_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of the iterations.
    start(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd18);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", OP_REMU, 32'd100, 32'd7, 5'd19, 32'd2, SLOW_LAT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
